// File: rtl/sdpram_be.sv
// rtl/sdpram_be.sv - simple dual-port RAM with byte enables, 1/2-cycle read latency and post-reset init
module sdpram_be #(
    parameter int               Depth       = 8,
    parameter int               Width       = 32,
    parameter int               ByteWidth   = 8,
    parameter int               NumBytes    = Width / ByteWidth,
    parameter int               PtrWidth    = $clog2(Depth),
    parameter int               ReadLatency = 1,
    parameter int               RdwMode     = 1,
    parameter int               InitOnReset = 1,
    parameter logic [Width-1:0] InitValue   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [PtrWidth-1:0] i_wr_addr,
    input  logic [Width-1:0]    i_wr_data,
    input  logic [NumBytes-1:0] i_wr_be,
    input  logic                i_rd_en,
    input  logic [PtrWidth-1:0] i_rd_addr,
    output logic [Width-1:0]    o_rd_data,
    output logic                o_rd_valid,
    output logic                o_ready
);

    typedef enum logic {INIT, READY} state_t;

    localparam logic [PtrWidth:0]   DepthP   = (PtrWidth + 1)'(Depth);
    localparam logic [PtrWidth-1:0] LastAddr = PtrWidth'(Depth - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PtrWidth-1:0] r_cnt;
    logic [PtrWidth-1:0] w_cnt_nxt;
    logic                w_ready;
    logic                w_wr_go;
    logic                w_rd_go;
    logic                w_wr_in_range;
    logic                w_rd_in_range;
    logic [Width-1:0]    w_rd_word;
    logic [Width-1:0]    r_ram [Depth];
    logic [Width-1:0]    r_d1;
    logic                r_v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= (InitOnReset != 0) ? INIT : READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == INIT) begin
            w_cnt_nxt = r_cnt + PtrWidth'(1);
            if (r_cnt == LastAddr) begin
                w_state_nxt = READY;
                w_cnt_nxt   = '0;
            end
        end
    end

    assign w_ready       = (r_state == READY);
    assign o_ready       = w_ready;
    assign w_wr_in_range = ({1'b0, i_wr_addr} < DepthP);
    assign w_rd_in_range = ({1'b0, i_rd_addr} < DepthP);
    assign w_wr_go       = w_ready && i_wr_en && w_wr_in_range;
    assign w_rd_go       = w_ready && i_rd_en;

    // Array has no reset; the init sequencer owns the write port while not READY.
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_ram[r_cnt] <= InitValue;
        end else if (w_wr_go) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (i_wr_be[k]) begin
                    r_ram[i_wr_addr][k*ByteWidth +: ByteWidth] <= i_wr_data[k*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    always_comb begin
        w_rd_word = w_rd_in_range ? r_ram[i_rd_addr] : '0;
        // Forward only the bytes being written this cycle (w_wr_go implies an in-range address).
        if ((RdwMode != 0) && w_wr_go && (i_wr_addr == i_rd_addr)) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (i_wr_be[k]) begin
                    w_rd_word[k*ByteWidth +: ByteWidth] = i_wr_data[k*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_go;
            if (w_rd_go) begin
                r_d1 <= w_rd_word;
            end
        end
    end

    generate
        if (ReadLatency == 2) begin : g_lat2
            logic [Width-1:0] r_d2;
            logic             r_v2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_d2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_d2 <= r_d1;
                    r_v2 <= r_v1;
                end
            end

            assign o_rd_data  = r_d2;
            assign o_rd_valid = r_v2;
        end else begin : g_lat1
            assign o_rd_data  = r_d1;
            assign o_rd_valid = r_v1;
        end
    endgenerate

endmodule
